rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one registered output resource, such as the priority-select/hold path, between N_REQ requesters.
- Issues a one-hot, registered grant and holds it until the owner signals done, drops its request, or exceeds a hold-time limit.
- Sits in front of the shared datapath; o_gnt drives the datapath's select/control inputs directly.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced release (2..256).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req  input  N_REQ  per-requester request level.
- i_done  input  1  current owner finished; sampled only while a grant is active.
- o_gnt  output  N_REQ  one-hot grant, registered; all-zero when idle.
- o_gnt_valid  output  1  OR of o_gnt, registered.
- o_gnt_idx  output  $clog2(N_REQ)  index of current owner; holds last owner while idle.
- o_timeout  output  1  single-cycle pulse, registered, marking a forced release.

Behaviour:
- Reset values:
  - o_gnt=0, o_gnt_valid=0, o_timeout=0.
  - o_gnt_idx=N_REQ-1, so the first search starts at index 0.
  - Hold counter=0; state=IDLE.
- States: IDLE, GRANT.
- Winner selection (combinational): first asserted i_req scanning from (o_gnt_idx+1) mod N_REQ upward with wrap. The scan includes o_gnt_idx itself as the last candidate.
- IDLE:
  - If i_req != 0 at edge k, then o_gnt, o_gnt_idx and o_gnt_valid show the winner from edge k+1. Latency is 1 cycle.
  - Counter loads 0; state moves to GRANT.
  - Otherwise remain in IDLE; outputs unchanged.
- GRANT, release condition R = i_done OR !i_req[o_gnt_idx] OR (counter == MAX_HOLD-1):
  - !R: keep grant; counter += 1.
  - R with any other i_req bit set:
    - Grant moves directly to the winner at the next edge, with no idle bubble. The scan starts at owner+1, so the old owner is chosen only if it is the sole requester.
    - Counter resets to 0.
  - R with no requester eligible (i_req all zero, or only the owner's bit set while the owner is releasing via done/timeout):
    - If the owner's bit is still set, it is re-granted, because the scan includes owner as the last candidate; counter resets to 0.
    - If i_req is all zero, state goes to IDLE and o_gnt=0 next cycle.
- o_timeout:
  - Asserts for exactly the cycle after a release caused solely by counter == MAX_HOLD-1.
  - If i_done or a dropped request coincides with expiry, the release is treated as normal and o_timeout stays 0.
- Grant occupancy: maximum MAX_HOLD consecutive cycles per grant, so the worst-case wait for any requester is (N_REQ-1)*(MAX_HOLD+0) cycles after its request.
- Invariants:
  - o_gnt is always zero or one-hot.
  - o_gnt_valid == |o_gnt.
  - o_gnt_idx matches the set bit whenever o_gnt_valid=1.
- i_done while in IDLE is ignored.
- Requests arriving in the same cycle as a release participate in that cycle's selection.
- Reset asserted mid-grant: outputs clear immediately (asynchronous); state returns to IDLE; the pointer returns to N_REQ-1.
- Counter width is $clog2(MAX_HOLD), and it never wraps: it clears on every release.

Decomposition:
- Shared package arb_pkg:
  - state enum arb_state_t {IDLE, GRANT};
  - function rr_pick(req, last_idx) returning {found, idx}.
- One sub-module, rr_priority_pick: combinational rotate-scan-unrotate winner finder (input req, ptr; output found, idx, onehot). It is reused by later arbiters.
- Top level contains the FSM, hold counter and output registers.

Test Plan:
1. After reset, i_req=4'b0000 for 5 cycles -> o_gnt=0, o_gnt_idx=3, o_gnt_valid=0 throughout.
2. i_req=4'b1111 held, i_done pulsed every 3rd grant cycle -> grants rotate 0,1,2,3,0 with no idle cycle between owners and no o_timeout.
3. i_req=4'b0100 only, i_done never, MAX_HOLD=16:
   - o_gnt=4'b0100 for 16 cycles, then o_timeout=1 for one cycle;
   - requester 2 is re-granted with the counter at 0.
4. Owner 1 granted with i_req=4'b0110; drop i_req[1] -> next edge o_gnt=4'b0100, o_timeout=0.
5. i_done and counter==MAX_HOLD-1 in the same cycle with i_req=4'b1001 and owner 0 -> grant moves to 3, o_timeout stays 0.
6. Assert i_rst mid-grant (owner 2), between clock edges -> o_gnt=0 immediately; after deassert with i_req=4'b1111, the first grant goes to index 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiters.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   rr_pick     : reference round-robin search over up to PICK_MAX requesters.
//                 Scans from last_idx+1 upward with wrap; last_idx itself is
//                 the final candidate. Returns {found, idx}.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int PICK_MAX = 16;

    // Unused upper request bits must be zero. With those bits zero, wrapping
    // modulo 16 picks the same winner as wrapping modulo the real count.
    function automatic logic [4:0] rr_pick(input logic [PICK_MAX-1:0] req,
                                           input logic [3:0]          last_idx);
        logic       found;
        logic [3:0] idx;
        logic [3:0] cand;
        found = 1'b0;
        idx   = last_idx;
        for (int i = 1; i <= PICK_MAX; i++) begin
            cand = 4'(int'(last_idx) + i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner finder.
//   req    : request vector
//   ptr    : index of the previous winner; the scan starts at ptr+1 and
//            ptr itself is the last candidate
//   found  : at least one request is set
//   idx    : winning index (don't-care when found=0)
//   onehot : winning requester as a one-hot vector (zero when found=0)
// Rotates req so the first candidate sits at bit 0, takes the lowest set
// bit, then maps the offset back to an absolute index.
module rr_priority_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] rot;
    int               off;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'((int'(ptr) + 1 + i) % N_REQ)];
        end
    end

    always_comb begin
        found = 1'b0;
        off   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
    end

    always_comb begin
        idx    = IDX_W'((int'(ptr) + 1 + off) % N_REQ);
        onehot = '0;
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter for a shared registered resource.
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-high reset
//   i_req       : per-requester request level
//   i_done      : current owner finished (ignored while idle)
//   o_gnt       : registered one-hot grant, zero when idle
//   o_gnt_valid : registered OR of o_gnt
//   o_gnt_idx   : current owner index, holds the last owner while idle
//   o_timeout   : one-cycle pulse after a release forced by the hold limit
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any request
// GRANT | o_gnt_idx owns the resource; hold counter tracks its tenure
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_done,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_gnt_valid,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_timeout
);

    arb_state_t       state;
    logic [CNT_W-1:0] hold_cnt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    logic owner_req;
    logic expiry;
    logic release_now;

    // The scan includes the owner as the last candidate, so a lone owner
    // that still requests is simply re-granted.
    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (i_req),
        .ptr    (o_gnt_idx),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign owner_req   = i_req[o_gnt_idx];
    assign expiry      = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now = i_done || !owner_req || expiry;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            o_gnt       <= '0;
            o_gnt_valid <= 1'b0;
            o_gnt_idx   <= IDX_W'(N_REQ - 1);
            o_timeout   <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        hold_cnt    <= '0;
                        o_gnt       <= pick_onehot;
                        o_gnt_valid <= 1'b1;
                        o_gnt_idx   <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!release_now) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else begin
                        hold_cnt <= '0;
                        // Only a release caused purely by the hold limit is flagged.
                        o_timeout <= expiry && !i_done && owner_req;
                        if (pick_found) begin
                            o_gnt     <= pick_onehot;
                            o_gnt_idx <= pick_idx;
                        end else begin
                            state       <= IDLE;
                            o_gnt       <= '0;
                            o_gnt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_gnt       <= '0;
                    o_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [N-1:0] i_req;
    logic         i_done;
    logic [N-1:0] o_gnt;
    logic         o_gnt_valid;
    logic [1:0]   o_gnt_idx;
    logic         o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_done      (i_done),
        .o_gnt       (o_gnt),
        .o_gnt_valid (o_gnt_valid),
        .o_gnt_idx   (o_gnt_idx),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner, whether a grant exists, and how many cycles
    // the current grant has been visible so far.
    int m_owner = N - 1;
    bit m_valid = 1'b0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    function automatic int next_from(input int own, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(own + k) % N]) return (own + k) % N;
        end
        return own;
    endfunction

    int m_next;
    bit m_timed;
    bit m_rel;
    assign m_next  = next_from(m_owner, i_req);
    assign m_timed = m_valid && (m_held == MH);
    assign m_rel   = i_done || !i_req[m_owner] || m_timed;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_owner <= N - 1;
            m_valid <= 1'b0;
            m_held  <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_valid) begin
                if (i_req != '0) begin
                    m_owner <= m_next;
                    m_valid <= 1'b1;
                    m_held  <= 1;
                end
            end else if (!m_rel) begin
                m_held <= m_held + 1;
            end else begin
                m_to <= m_timed && !i_done && i_req[m_owner];
                if (i_req == '0) begin
                    m_valid <= 1'b0;
                end else begin
                    m_owner <= m_next;
                    m_held  <= 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        chk("model_gnt",   32'(o_gnt),       m_valid ? (32'd1 << m_owner) : 32'd0);
        chk("model_valid", 32'(o_gnt_valid), 32'(m_valid));
        chk("model_idx",   32'(o_gnt_idx),   32'(m_owner));
        chk("model_to",    32'(o_timeout),   32'(m_to));
        chk("onehot",      32'($countones(o_gnt) <= 1), 32'd1);
        chk("valid_or",    32'(o_gnt_valid), 32'(|o_gnt));
    end

    task automatic step(input logic [N-1:0] r, input logic d);
        i_req  = r;
        i_done = d;
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        i_rst  = 1'b1;
        i_req  = '0;
        i_done = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // 1: idle after reset
        chk("rst_gnt",   32'(o_gnt),       32'd0);
        chk("rst_idx",   32'(o_gnt_idx),   32'd3);
        chk("rst_valid", 32'(o_gnt_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0);
            chk("idle_gnt", 32'(o_gnt), 32'd0);
            chk("idle_idx", 32'(o_gnt_idx), 32'd3);
        end

        // 2: full request, done every 3rd grant cycle
        step(4'b1111, 1'b0);
        chk("rr_first", 32'(o_gnt), 32'b0001);
        for (int k = 1; k <= 4; k++) begin
            step(4'b1111, 1'b0);
            chk("rr_hold_valid", 32'(o_gnt_valid), 32'd1);
            step(4'b1111, 1'b0);
            chk("rr_hold_valid", 32'(o_gnt_valid), 32'd1);
            step(4'b1111, 1'b1);
            chk("rr_rotate", 32'(o_gnt), 32'd1 << (k % 4));
            chk("rr_no_to", 32'(o_timeout), 32'd0);
        end

        // 3: lone requester 2 hits the hold limit and is re-granted
        step(4'b0000, 1'b0);
        chk("drop_idle", 32'(o_gnt_valid), 32'd0);
        step(4'b0100, 1'b0);
        chk("lone_gnt", 32'(o_gnt), 32'b0100);
        for (int i = 0; i < 15; i++) begin
            step(4'b0100, 1'b0);
            chk("lone_hold", 32'(o_gnt), 32'b0100);
            chk("lone_no_to", 32'(o_timeout), 32'd0);
        end
        step(4'b0100, 1'b0);
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_regrant", 32'(o_gnt), 32'b0100);
        for (int i = 0; i < 15; i++) begin
            step(4'b0100, 1'b0);
            chk("regrant_no_to", 32'(o_timeout), 32'd0);
        end
        step(4'b0100, 1'b0);
        chk("to_second", 32'(o_timeout), 32'd1);

        // 4: owner 1 drops its request, 2 takes over
        step(4'b0000, 1'b0);
        step(4'b0110, 1'b0);
        chk("own1_gnt", 32'(o_gnt), 32'b0010);
        step(4'b0100, 1'b0);
        chk("drop_move", 32'(o_gnt), 32'b0100);
        chk("drop_no_to", 32'(o_timeout), 32'd0);

        // 5: done coincides with expiry
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        chk("own0_gnt", 32'(o_gnt), 32'b0001);
        for (int i = 0; i < 15; i++) begin
            step(4'b1001, 1'b0);
        end
        chk("own0_still", 32'(o_gnt), 32'b0001);
        step(4'b1001, 1'b1);
        chk("done_exp_move", 32'(o_gnt), 32'b1000);
        chk("done_exp_no_to", 32'(o_timeout), 32'd0);

        // 6: asynchronous reset mid-grant
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        chk("own2_gnt", 32'(o_gnt), 32'b0100);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_gnt",   32'(o_gnt),       32'd0);
        chk("async_valid", 32'(o_gnt_valid), 32'd0);
        chk("async_idx",   32'(o_gnt_idx),   32'd3);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(4'b1111, 1'b0);
        chk("post_rst_gnt", 32'(o_gnt), 32'b0001);
        chk("post_rst_idx", 32'(o_gnt_idx), 32'd0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
